regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 103 ++++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read-port register file with per-register busy
//            (scoreboard) bits and a running count of busy registers.
//            Register 0 is hardwired to zero and is never busy.
// Options  : REGFILE_BYPASS_EN - when defined, a write in flight is forwarded
//            to any read port addressing the same nonzero register in the
//            same cycle (data = wdata, busy = 0).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rd_busy,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [ADDR_W:0]    r_busy_cnt;

  logic w_wr;      // qualified write (nonzero address)
  logic w_rsv;     // qualified reserve (nonzero address)
  logic w_set;     // reserve turns a clear bit on
  logic w_clr;     // write turns a set bit off and is not re-reserved

  assign w_wr  = we && (waddr != '0);
  assign w_rsv = rsv_en && (rsv_addr != '0);
  assign w_set = w_rsv && !r_busy[rsv_addr];
  assign w_clr = w_wr && r_busy[waddr] && !(w_rsv && (rsv_addr == waddr));

  // Array, busy bits and counter update; reserve is applied after the write
  // so that a same-address reserve leaves the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[waddr]  <= wdata;
        r_busy[waddr] <= 1'b0;
      end
      if (w_rsv) begin
        r_busy[rsv_addr] <= 1'b1;
      end
      r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_set}
                               - {{ADDR_W{1'b0}}, w_clr};
    end
  end

  assign busy_cnt = r_busy_cnt;

  // One combinational read port per k; address 0 is forced to zero / not busy.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_byp;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_ra = raddr[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    assign w_byp = w_wr && (w_ra == waddr);
`else
    assign w_byp = 1'b0;
`endif

    // Select zero register, forwarded write, or stored contents.
    always_comb begin
      w_data = r_mem[w_ra];
      w_bsy  = r_busy[w_ra];
      if (w_ra == '0) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end else if (w_byp) begin
        w_data = wdata;
        w_bsy  = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = w_data;
    assign rd_busy[k]                = w_bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb. Stimulus pushes expected
//            read-port results into a scoreboard queue; a monitor on the
//            falling edge pops each entry and compares it with the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  rsv_en;
  logic [ADDR_W-1:0]     rsv_addr;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rd_busy;
  logic [ADDR_W:0]       busy_cnt;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr(raddr),
    .rdata(rdata), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              port;
    logic [31:0]     data;
    logic            busy;
    logic [ADDR_W:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (rdata[e.port*DATA_W +: DATA_W] !== e.data) begin
          n_fail++;
          $display("FAIL %s p%0d rdata: got %h want %h", e.name, e.port,
                   rdata[e.port*DATA_W +: DATA_W], e.data);
        end
        n_tests++;
        if (rd_busy[e.port] !== e.busy) begin
          n_fail++;
          $display("FAIL %s p%0d rd_busy: got %b want %b", e.name, e.port,
                   rd_busy[e.port], e.busy);
        end
        n_tests++;
        if (busy_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s busy_cnt: got %0d want %0d", e.name, busy_cnt, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int a0, input int a1);
    raddr = {a1[ADDR_W-1:0], a0[ADDR_W-1:0]};
  endtask

  task automatic expect_rd(input string nm, input int port, input logic [31:0] d,
                           input logic b, input int c);
    exp_t e;
    e.name = nm; e.port = port; e.data = d; e.busy = b; e.cnt = c[ADDR_W:0];
    sb.push_back(e);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1; waddr = a[ADDR_W-1:0]; wdata = d;
  endtask

  task automatic rsv(input int a);
    rsv_en = 1'b1; rsv_addr = a[ADDR_W-1:0];
  endtask

  task automatic idle();
    we = 1'b0; rsv_en = 1'b0; rst = 1'b0;
  endtask

  // Hand-tracked register contents just before the reserve sweep.
  function automatic logic [31:0] hand_val(input int a);
    case (a)
      3:       return 32'h0000_0033;
      4:       return 32'hA5A5_A5A5;
      5:       return 32'h0000_5555;
      7:       return 32'h0000_0077;
      9:       return 32'h0000_0099;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; raddr = '0;
    repeat (2) tick();
    idle();

    // Reset state on every address, both ports.
    for (int a = 0; a < 32; a++) begin
      set_ra(a, 31 - a);
      expect_rd("reset_p0", 0, 32'h0, 1'b0, 0);
      expect_rd("reset_p1", 1, 32'h0, 1'b0, 0);
      tick();
    end

    // Reserve r5, observe busy, then write it.
    rsv(5); set_ra(5, 0);
    expect_rd("rsv5_pre", 0, 32'h0, 1'b0, 0);
    tick(); idle(); set_ra(5, 0);
    expect_rd("r5_busy", 0, 32'h0, 1'b1, 1);
    tick(); wr(5, 32'hDEAD_BEEF); set_ra(5, 0);
    expect_rd("r5_wr_same", 0, c_BYP ? 32'hDEAD_BEEF : 32'h0, !c_BYP, 1);
    tick(); idle(); rsv(9); set_ra(5, 9);
    expect_rd("r5_after", 0, 32'hDEAD_BEEF, 1'b0, 0);
    expect_rd("r9_pre", 1, 32'h0, 1'b0, 0);

    // Same-address reserve and write on r7 (reserve wins).
    tick(); idle(); rsv(7); wr(7, 32'h12); set_ra(7, 9);
    expect_rd("r7_rw_same", 0, c_BYP ? 32'h12 : 32'h0, 1'b0, 1);
    expect_rd("r9_busy", 1, 32'h0, 1'b1, 1);

    // Reserve r3 while writing busy r9: net count change zero.
    tick(); idle(); rsv(3); wr(9, 32'h99); set_ra(7, 9);
    expect_rd("r7_after", 0, 32'h12, 1'b1, 2);
    expect_rd("r9_wr_same", 1, c_BYP ? 32'h99 : 32'h0, !c_BYP, 2);

    // Write a non-busy register: count unchanged.
    tick(); idle(); wr(5, 32'h5555); set_ra(3, 9);
    expect_rd("r3_busy", 0, 32'h0, 1'b1, 2);
    expect_rd("r9_after", 1, 32'h99, 1'b0, 2);

    // Reserve an already-busy register: count unchanged.
    tick(); idle(); rsv(7); set_ra(5, 7);
    expect_rd("r5_nonbusy_wr", 0, 32'h5555, 1'b0, 2);
    expect_rd("r7_rersv_pre", 1, 32'h12, 1'b1, 2);

    // Drain busy registers r7 and r3.
    tick(); idle(); wr(7, 32'h77); set_ra(7, 3);
    expect_rd("r7_rersv", 0, c_BYP ? 32'h77 : 32'h12, !c_BYP, 2);
    expect_rd("r3_still", 1, 32'h0, 1'b1, 2);
    tick(); idle(); wr(3, 32'h33); set_ra(7, 3);
    expect_rd("r7_clr", 0, 32'h77, 1'b0, 1);
    expect_rd("r3_wr_same", 1, c_BYP ? 32'h33 : 32'h0, !c_BYP, 1);

    // Register 0: write and reserve both ignored, never forwarded.
    tick(); idle(); wr(0, 32'hFFFF_FFFF); rsv(0); set_ra(0, 3);
    expect_rd("r0_wr_same", 0, 32'h0, 1'b0, 0);
    expect_rd("r3_clr", 1, 32'h33, 1'b0, 0);
    tick(); idle(); set_ra(0, 0);
    expect_rd("r0_after", 0, 32'h0, 1'b0, 0);
    expect_rd("r0_after_p1", 1, 32'h0, 1'b0, 0);

    // Forwarding of r4, then we=0 with matching waddr has no effect.
    tick(); idle(); wr(4, 32'hA5A5_A5A5); set_ra(4, 0);
    expect_rd("r4_wr_same", 0, c_BYP ? 32'hA5A5_A5A5 : 32'h0, 1'b0, 0);
    tick(); idle(); waddr = 5'd4; wdata = 32'h1111_1111; set_ra(4, 4);
    expect_rd("r4_we0_p0", 0, 32'hA5A5_A5A5, 1'b0, 0);
    expect_rd("r4_we0_p1", 1, 32'hA5A5_A5A5, 1'b0, 0);
    tick(); idle(); set_ra(4, 0);
    expect_rd("r4_we0_after", 0, 32'hA5A5_A5A5, 1'b0, 0);

    // Reserve r1..r31, counting up to the maximum.
    for (int a = 1; a < 32; a++) begin
      tick(); idle(); rsv(a); set_ra(0, a);
      expect_rd("sweep_r0", 0, 32'h0, 1'b0, a - 1);
      expect_rd("sweep_ra", 1, hand_val(a), 1'b0, a - 1);
    end

    // Full count, then reset overriding reserve and write.
    tick(); idle(); set_ra(31, 0);
    expect_rd("full_r31", 0, 32'h0, 1'b1, 31);
    expect_rd("full_r0", 1, 32'h0, 1'b0, 31);
    tick(); rst = 1'b1; rsv(5); wr(6, 32'h1); set_ra(5, 4);
    expect_rd("rst_pre_r5", 0, 32'h0000_5555, 1'b1, 31);
    expect_rd("rst_pre_r4", 1, 32'hA5A5_A5A5, 1'b1, 31);
    tick(); idle(); set_ra(5, 4);
    expect_rd("rst_r5", 0, 32'h0, 1'b0, 0);
    expect_rd("rst_r4", 1, 32'h0, 1'b0, 0);
    tick(); idle(); set_ra(6, 7);
    expect_rd("rst_r6", 0, 32'h0, 1'b0, 0);
    expect_rd("rst_r7", 1, 32'h0, 1'b0, 0);
    tick();
    done = 1'b1;
  end

  // Bounded wait for the scoreboard to drain, then summary.
  initial begin
    int guard;
    guard = 0;
    while (!(done && sb.size() == 0) && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
